// File: rtl/ext_pkg.sv
// Shared extension-mode encodings for the immediate extender and its users.
package ext_pkg;

  typedef enum logic [2:0] {
    EOP_SIGN   = 3'b000,
    EOP_ZERO   = 3'b001,
    EOP_HIGH   = 3'b010,
    EOP_SSHIFT = 3'b011,
    EOP_SB     = 3'b100,
    EOP_ZB     = 3'b101,
    EOP_SH     = 3'b110,
    EOP_ILL    = 3'b111
  } eop_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: maps a raw immediate and mode to an OUT_W result.
module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  i_imm,
  input  logic [2:0]       i_eop,
  output logic [OUT_W-1:0] o_data,
  output logic             o_err
);

  localparam int HALF_W = IN_W / 2;

  logic signed [IN_W-1:0]   w_imm_s;
  logic signed [7:0]        w_byte_s;
  logic signed [HALF_W-1:0] w_half_s;
  logic signed [OUT_W-1:0]  w_sx;

  assign w_imm_s  = i_imm;
  assign w_byte_s = i_imm[7:0];
  assign w_half_s = i_imm[HALF_W-1:0];
  assign w_sx     = OUT_W'(w_imm_s);

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (eop_e'(i_eop))
      EOP_SIGN:   o_data = w_sx;
      EOP_ZERO:   o_data = OUT_W'(i_imm);
      EOP_HIGH:   o_data = OUT_W'(i_imm) << (OUT_W - IN_W);
      EOP_SSHIFT: o_data = w_sx << SHAMT;
      EOP_SB:     o_data = OUT_W'(w_byte_s);
      EOP_ZB:     o_data = OUT_W'(i_imm[7:0]);
      EOP_SH:     o_data = OUT_W'(w_half_s);
      EOP_ILL:    o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a 2-entry output buffer and a saturating illegal-op counter.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       r_occ;
  logic [OUT_W-1:0] r_data_p0, r_data_p1;
  logic             r_err_p0, r_err_p1;
  logic [CNT_W-1:0] r_err_cnt;

  logic [OUT_W-1:0] w_ext_data;
  logic             w_ext_err;
  logic             w_push, w_pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHAMT (SHAMT)
  ) u_core (
    .i_imm  (imm),
    .i_eop  (eop),
    .o_data (w_ext_data),
    .o_err  (w_ext_err)
  );

  assign in_ready  = (r_occ != 2'd2);
  assign out_valid = (r_occ != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data  = r_data_p0;
  assign out_err   = r_err_p0;
  assign err_cnt   = r_err_cnt;

  // p0 is the head presented downstream; p1 holds the second entry when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ     <= 2'd0;
      r_data_p0 <= '0;
      r_data_p1 <= '0;
      r_err_p0  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push && w_ext_err)
        r_err_cnt <= sat_inc(r_err_cnt);
      case (r_occ)
        2'd0: begin
          if (w_push) begin
            r_data_p0 <= w_ext_data;
            r_err_p0  <= w_ext_err;
            r_occ     <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_data_p0 <= w_ext_data;
            r_err_p0  <= w_ext_err;
          end else if (w_push) begin
            r_data_p1 <= w_ext_data;
            r_err_p1  <= w_ext_err;
            r_occ     <= 2'd2;
          end else if (w_pop) begin
            r_occ     <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_data_p0 <= r_data_p1;
            r_err_p0  <= r_err_p1;
            r_occ     <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and randomized checks of imm_ext_pipe at default parameters.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [2:0]  eop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;

  imm_ext_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .eop       (eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ref_ext(input logic [15:0] i, input logic [2:0] e);
    case (e)
      3'd0: return {1'b0, {16{i[15]}}, i};
      3'd1: return {1'b0, 16'h0000, i};
      3'd2: return {1'b0, i, 16'h0000};
      3'd3: return {1'b0, {14{i[15]}}, i, 2'b00};
      3'd4: return {1'b0, {24{i[7]}}, i[7:0]};
      3'd5: return {1'b0, 24'h000000, i[7:0]};
      3'd6: return {1'b0, {24{i[7]}}, i[7:0]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  logic [15:0] v_imm [7] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0080, 16'h0080, 16'h0080};
  logic [2:0]  v_eop [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [31:0] v_exp [7] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004,
                             32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] q[$];
    logic [32:0] held;
    logic        held_v;
    logic [7:0]  m_cnt;
    logic        do_push, do_pop;
    int          pushes, cycles, exp_cnt;

    rst_n = 1'b1; in_valid = 1'b0; imm = '0; eop = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_err",   out_err, 0);
    chk("rst_err_cnt",   err_cnt, 0);

    // first vector is offered on the very first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; imm = v_imm[i]; eop = v_eop[i];
      step();
      chk($sformatf("mode%0d_valid", v_eop[i]), out_valid, 1);
      chk($sformatf("mode%0d_data", v_eop[i]), {out_err, out_data}, {1'b0, v_exp[i]});
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);

    // backpressure: A, B fill the buffer, C must wait
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0080; eop = 3'd4;
    step();
    chk("bp_ready1", in_ready, 1);
    imm = 16'h8001; eop = 3'd1;
    step();
    chk("bp_ready2", in_ready, 0);
    chk("bp_headA", out_data, 32'hFFFFFF80);
    imm = 16'h8001; eop = 3'd2;
    step();
    chk("bp_ready3", in_ready, 0);
    chk("bp_holdA", out_data, 32'hFFFFFF80);
    out_ready = 1'b1;
    step();
    chk("bp_headB", out_data, 32'h00008001);
    chk("bp_ready_up", in_ready, 1);
    step();
    chk("bp_headC", out_data, 32'h80010000);
    chk("bp_validC", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);

    // illegal ops: counter saturates at 255
    in_valid = 1'b1; imm = 16'h1234; eop = 3'd7;
    for (int k = 0; k < 300; k++) begin
      step();
      chk("ill_data", {out_err, out_data}, {1'b1, 32'h0});
      exp_cnt = (k + 1 > 255) ? 255 : k + 1;
      chk("ill_cnt", err_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    step();

    // asynchronous reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0080; eop = 3'd5;
    step();
    imm = 16'h8001; eop = 3'd3;
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt",   err_cnt, 0);
    chk("mid_rst_data",  {out_err, out_data}, 33'h0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; imm = 16'h8001; eop = 3'd0;
    step();
    chk("post_rst_first", {out_err, out_data}, {1'b0, 32'hFFFF8001});
    in_valid = 1'b0;
    step();
    chk("post_rst_empty", out_valid, 0);

    // randomized valid/ready against a queue model
    pushes = 0; cycles = 0; held_v = 1'b0; held = '0; m_cnt = '0;
    while (pushes < 10000 && cycles < 60000) begin
      chk("rnd_in_ready", in_ready, (q.size() < 2) ? 1 : 0);
      chk("rnd_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      chk("rnd_err_cnt", err_cnt, m_cnt);
      if (held_v) chk("rnd_stall_hold", {out_err, out_data}, held);
      in_valid  = ($urandom_range(0, 3) != 0);
      imm       = 16'($urandom);
      eop       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop && q.size() > 0) chk("rnd_data", {out_err, out_data}, q[0]);
      held_v = out_valid && !out_ready;
      held   = {out_err, out_data};
      step();
      cycles++;
      if (do_pop && q.size() > 0) void'(q.pop_front());
      if (do_push) begin
        q.push_back(ref_ext(imm, eop));
        pushes++;
        if (eop == 3'd7 && m_cnt != 8'hFF) m_cnt++;
      end
    end
    chk("rnd_done", pushes, 10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
